// File: rtl/microseq_pkg.sv
// microseq_pkg: shared encodings, control-word field positions and dispatch targets for the microsequencer
package microseq_pkg;
    localparam logic [2:0] NS_INC   = 3'd0;
    localparam logic [2:0] NS_JMP   = 3'd1;
    localparam logic [2:0] NS_DISP  = 3'd2;
    localparam logic [2:0] NS_CBR   = 3'd3;
    localparam logic [2:0] NS_WAIT  = 3'd4;
    localparam logic [2:0] NS_CDISP = 3'd5;
    localparam logic [2:0] NS_CALL  = 3'd6;
    localparam logic [2:0] NS_RET   = 3'd7;

    localparam logic [1:0] CSEL_COND = 2'd0;
    localparam logic [1:0] CSEL_L    = 2'd1;
    localparam logic [1:0] CSEL_P    = 2'd2;
    localparam logic [1:0] CSEL_U    = 2'd3;

    localparam int NS_HI   = 44;
    localparam int NS_LO   = 42;
    localparam int INV_BIT = 41;
    localparam int CSEL_HI = 40;
    localparam int CSEL_LO = 39;
    localparam int CR_HI   = 6;
    localparam int CR_LO   = 0;

    localparam logic [6:0] ADDR_UNDEF     = 7'd0;
    localparam logic [6:0] ADDR_DP_ISHIFT = 7'd4;
    localparam logic [6:0] ADDR_DP_RSHIFT = 7'd6;
    localparam logic [6:0] ADDR_DP_IMM    = 7'd8;
    localparam logic [6:0] ADDR_LDR_IMM   = 7'd11;
    localparam logic [6:0] ADDR_LDR_REG   = 7'd13;
    localparam logic [6:0] ADDR_BRANCH    = 7'd40;
    localparam logic [6:0] ADDR_STR_IMM   = 7'd45;
    localparam logic [6:0] ADDR_STR_REG   = 7'd47;
    localparam logic [6:0] ADDR_BLOCK     = 7'd81;
endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: maps the instruction register to the microprogram start address of its class
//   ir   in  32  instruction register
//   addr out 7   dispatch target
module instr_encoder
    import microseq_pkg::*;
(
    input  logic [31:0] ir,
    output logic [6:0]  addr
);
    logic [2:0] op;
    logic       unused_ir;

    assign op        = ir[27:25];
    assign unused_ir = ^{ir[31:28], ir[24:21], ir[19:5], ir[3:0]};

    always_comb begin
        addr = op == 3'b000 ? (ir[4] ? ADDR_DP_RSHIFT : ADDR_DP_ISHIFT) :
               op == 3'b001 ? ADDR_DP_IMM :
               op == 3'b010 ? (ir[20] ? ADDR_LDR_IMM : ADDR_STR_IMM) :
               op == 3'b011 ? (ir[20] ? ADDR_LDR_REG : ADDR_STR_REG) :
               op == 3'b100 ? ADDR_BLOCK :
               op == 3'b101 ? ADDR_BRANCH : ADDR_UNDEF;
    end
endmodule

// File: rtl/microsequencer.sv
// microsequencer: microprogram counter and next-address logic for the ARM control unit
//   clk, reset (sync, active-high); cw control word for current index; ir instruction;
//   cond_true condition test; moc memory complete; index uPC; stall wait hold; fault sticky timeout.
//   Define MICROSEQ_SUBR_EN to build the one-entry call/return register (ns=6/7).
module microsequencer
    import microseq_pkg::*;
#(
    parameter int         WAIT_LIMIT = 16,
    parameter logic [6:0] FAULT_ADDR = 7'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [44:0] cw,
    input  logic [31:0] ir,
    input  logic        cond_true,
    input  logic        moc,
    output logic [6:0]  index,
    output logic        stall,
    output logic        fault
);
    logic [2:0] ns;
    logic [1:0] csel;
    logic [6:0] cr, inc, disp, nxt;
    logic       sel, c, waiting, timeout;
    logic [7:0] wcnt;
    logic       unused_cw;

    assign ns        = cw[NS_HI:NS_LO];
    assign csel      = cw[CSEL_HI:CSEL_LO];
    assign cr        = cw[CR_HI:CR_LO];
    assign unused_cw = ^cw[38:7];
    assign inc       = index + 7'd1;

    instr_encoder u_enc (.ir(ir), .addr(disp));

    assign sel = csel == CSEL_COND ? cond_true :
                 csel == CSEL_L    ? ir[20] :
                 csel == CSEL_P    ? ir[24] : ir[23];
    assign c   = sel ^ cw[INV_BIT];

    assign waiting = ns == NS_WAIT && !moc;
    // moc on the limit cycle clears waiting, so it wins over the timeout
    assign timeout = waiting && wcnt == 8'(WAIT_LIMIT - 1);
    assign stall   = !reset && waiting;

`ifdef MICROSEQ_SUBR_EN
    logic [6:0] ret_addr;

    always_ff @(posedge clk) begin
        if (reset)
            ret_addr <= 7'd0;
        else if (ns == NS_CALL)
            ret_addr <= inc;
    end
`endif

    always_comb begin
        nxt = inc;
        case (ns)
            NS_JMP:   nxt = cr;
            NS_DISP:  nxt = disp;
            NS_CBR:   nxt = c ? cr : inc;
            NS_WAIT:  nxt = timeout ? FAULT_ADDR : moc ? inc : index;
            NS_CDISP: nxt = c ? disp : cr;
`ifdef MICROSEQ_SUBR_EN
            NS_CALL:  nxt = cr;
            NS_RET:   nxt = ret_addr;
`endif
            default:  nxt = inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index <= 7'd0;
            fault <= 1'b0;
            wcnt  <= 8'd0;
        end else begin
            index <= nxt;
            fault <= fault | timeout;
            wcnt  <= (waiting && !timeout) ? wcnt + 8'd1 : 8'd0;
        end
    end
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed self-checking bench for the microsequencer
module tb_microsequencer;
    logic        clk = 0;
    logic        reset = 1;
    logic [44:0] cw = '0;
    logic [31:0] ir = '0;
    logic        cond_true = 0;
    logic        moc = 0;
    logic [6:0]  index;
    logic        stall, fault;
    int          tests = 0;
    int          fails = 0;

    microsequencer dut (
        .clk(clk), .reset(reset), .cw(cw), .ir(ir), .cond_true(cond_true),
        .moc(moc), .index(index), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [44:0] mk(input logic [2:0] ns, input logic inv,
                                       input logic [1:0] csel, input logic [6:0] cr);
        logic [44:0] w;
        w = '0;
        w[44:42] = ns;
        w[41] = inv;
        w[40:39] = csel;
        w[6:0] = cr;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [6:0] a);
        cw = mk(3'd1, 0, 2'd0, a);
        step();
    endtask

    task automatic test_reset();
        reset = 1; moc = 0; cw = mk(3'd0, 0, 2'd0, 7'd0);
        step(); step();
        tests++; if (index !== 7'd0) begin fails++; $display("FAIL reset_index got %0d want 0", index); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", fault); end
        reset = 0;
        step();
        tests++; if (index !== 7'd1) begin fails++; $display("FAIL inc1 got %0d want 1", index); end
        step();
        tests++; if (index !== 7'd2) begin fails++; $display("FAIL inc2 got %0d want 2", index); end
    endtask

    task automatic test_dispatch();
        ir = 32'hE0810002; cw = mk(3'd2, 0, 2'd0, 7'd0);
        step();
        tests++; if (index !== 7'd4) begin fails++; $display("FAIL disp_add got %0d want 4", index); end
        ir = 32'hEA000001;
        step();
        tests++; if (index !== 7'd40) begin fails++; $display("FAIL disp_b got %0d want 40", index); end
        ir = 32'hE0810012;
        step();
        tests++; if (index !== 7'd6) begin fails++; $display("FAIL disp_rshift got %0d want 6", index); end
        ir = 32'hE5900000;
        step();
        tests++; if (index !== 7'd11) begin fails++; $display("FAIL disp_ldr got %0d want 11", index); end
        ir = 32'hE7800000;
        step();
        tests++; if (index !== 7'd47) begin fails++; $display("FAIL disp_strreg got %0d want 47", index); end
        ir = 32'hE8900000;
        step();
        tests++; if (index !== 7'd81) begin fails++; $display("FAIL disp_block got %0d want 81", index); end
        ir = 32'hEE000000;
        step();
        tests++; if (index !== 7'd0) begin fails++; $display("FAIL disp_undef got %0d want 0", index); end
    endtask

    task automatic test_cbr();
        jump_to(7'd30);
        cond_true = 1; cw = mk(3'd3, 0, 2'd0, 7'd92);
        step();
        tests++; if (index !== 7'd92) begin fails++; $display("FAIL cbr_taken got %0d want 92", index); end
        jump_to(7'd30);
        cond_true = 0; cw = mk(3'd3, 0, 2'd0, 7'd92);
        step();
        tests++; if (index !== 7'd31) begin fails++; $display("FAIL cbr_not got %0d want 31", index); end
        jump_to(7'd30);
        cond_true = 1; cw = mk(3'd3, 1, 2'd0, 7'd92);
        step();
        tests++; if (index !== 7'd31) begin fails++; $display("FAIL cbr_inv got %0d want 31", index); end
        jump_to(7'd30);
        ir = 32'h01000000; cw = mk(3'd3, 0, 2'd2, 7'd70);
        step();
        tests++; if (index !== 7'd70) begin fails++; $display("FAIL cbr_ir24 got %0d want 70", index); end
        jump_to(7'd30);
        ir = 32'h01000000; cw = mk(3'd3, 0, 2'd3, 7'd70);
        step();
        tests++; if (index !== 7'd31) begin fails++; $display("FAIL cbr_ir23 got %0d want 31", index); end
        cond_true = 0;
    endtask

    task automatic test_cdisp();
        jump_to(7'd50);
        ir = 32'hE5900000; cw = mk(3'd5, 0, 2'd1, 7'd33);
        step();
        tests++; if (index !== 7'd11) begin fails++; $display("FAIL cdisp_pass got %0d want 11", index); end
        ir = 32'hE5800000;
        step();
        tests++; if (index !== 7'd33) begin fails++; $display("FAIL cdisp_fail got %0d want 33", index); end
    endtask

    task automatic test_wait();
        jump_to(7'd9);
        moc = 0; cw = mk(3'd4, 0, 2'd0, 7'd0);
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL wait_stall0 got %b want 1", stall); end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (index !== 7'd9 || stall !== 1'b1) begin
                fails++; $display("FAIL wait_hold%0d got idx=%0d stall=%b want 9/1", i, index, stall);
            end
        end
        moc = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL wait_moc_stall got %b want 0", stall); end
        step();
        tests++; if (index !== 7'd10 || fault !== 1'b0) begin
            fails++; $display("FAIL wait_release got idx=%0d fault=%b want 10/0", index, fault);
        end
        moc = 0;
        jump_to(7'd9);
        cw = mk(3'd4, 0, 2'd0, 7'd0);
        for (int i = 0; i < 15; i++) step();
        tests++; if (index !== 7'd9 || fault !== 1'b0) begin
            fails++; $display("FAIL wait_pre_timeout got idx=%0d fault=%b want 9/0", index, fault);
        end
        step();
        tests++; if (index !== 7'd0 || fault !== 1'b1) begin
            fails++; $display("FAIL wait_timeout got idx=%0d fault=%b want 0/1", index, fault);
        end
        cw = mk(3'd0, 0, 2'd0, 7'd0);
        step(); step();
        tests++; if (fault !== 1'b1 || index !== 7'd2) begin
            fails++; $display("FAIL fault_sticky got idx=%0d fault=%b want 2/1", index, fault);
        end
    endtask

    task automatic test_moc_wins();
        jump_to(7'd60);
        moc = 0; cw = mk(3'd4, 0, 2'd0, 7'd0);
        for (int i = 0; i < 15; i++) step();
        moc = 1;
        step();
        tests++; if (index !== 7'd61) begin fails++; $display("FAIL moc_wins got %0d want 61", index); end
        moc = 0;
    endtask

    task automatic test_wrap_reset();
        jump_to(7'd127);
        cw = mk(3'd0, 0, 2'd0, 7'd0);
        step();
        tests++; if (index !== 7'd0) begin fails++; $display("FAIL wrap got %0d want 0", index); end
        jump_to(7'd9);
        moc = 0; cw = mk(3'd4, 0, 2'd0, 7'd0);
        step();
        reset = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_comb got %b want 0", stall); end
        moc = 1;
        step();
        tests++; if (index !== 7'd0 || stall !== 1'b0 || fault !== 1'b0) begin
            fails++; $display("FAIL midwait_reset got idx=%0d stall=%b fault=%b want 0/0/0", index, stall, fault);
        end
        reset = 0; moc = 0;
        cw = mk(3'd0, 0, 2'd0, 7'd0);
    endtask

    task automatic test_subr();
        jump_to(7'd20);
        cw = mk(3'd6, 0, 2'd0, 7'd90);
        step();
`ifdef MICROSEQ_SUBR_EN
        tests++; if (index !== 7'd90) begin fails++; $display("FAIL call got %0d want 90", index); end
        cw = mk(3'd7, 0, 2'd0, 7'd0);
        step();
        tests++; if (index !== 7'd21) begin fails++; $display("FAIL ret got %0d want 21", index); end
`else
        tests++; if (index !== 7'd21) begin fails++; $display("FAIL call_as_inc got %0d want 21", index); end
        cw = mk(3'd7, 0, 2'd0, 7'd0);
        step();
        tests++; if (index !== 7'd22) begin fails++; $display("FAIL ret_as_inc got %0d want 22", index); end
`endif
    endtask

    initial begin
        #2;
        test_reset();
        test_dispatch();
        test_cbr();
        test_cdisp();
        test_wait();
        test_moc_wins();
        test_wrap_reset();
        test_subr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/microsequencer.md
# microsequencer

Microprogram sequencer for the ARM control unit. Holds the microprogram counter, drives the 7-bit index into the 45-bit microstore ROM, and computes the next index from the returned control word, the instruction register, the condition tester and memory handshake. The ROM is combinational. Sequencer plus ROM form the complete control unit.

## Interface
- `WAIT_LIMIT`, default 16: number of cycles a wait microinstruction may stall before a fault.
- `FAULT_ADDR`, default 7'd0: index forced on a wait timeout.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cw`  in  45: control word from the microstore for the current `index`.
- `ir`  in  32: instruction register contents.
- `cond_true`  in  1: ARM condition-code test result for `ir[31:28]`.
- `moc`  in  1: memory operation complete.
- `index`  out  7: microstore address, which is the registered µPC.
- `stall`  out  1: high while a wait microinstruction is holding.
- `fault`  out  1: sticky flag, set on a wait timeout.

## Operation
**Control-word fields**
- `cw[44:42]`: ns, the next-state select.
- `cw[41]`: inv, inverts the selected condition.
- `cw[40:39]`: csel, the condition select.
  - 0: `cond_true`
  - 1: `ir[20]`
  - 2: `ir[24]`
  - 3: `ir[23]`
- `cw[6:0]`: cr, the target address.
- Other bits are datapath controls and are ignored here.
- The condition is c = selected bit XOR inv.

**Next-address select (ns)**
- 0: increment, next = index+1.
- 1: jump, next = cr.
- 2: dispatch, next = `instr_encoder(ir)`.
- 3: conditional branch, next = c ? cr : index+1.
- 4: wait.
  - If `moc` is high: next = index+1.
  - If `moc` is low: hold the index and assert `stall`.
- 5: conditional dispatch, next = c ? dispatch : cr. Used for the condition-fail path.
- 6/7: call/return, see Configuration.

**Dispatch map (`instr_encoder`)**

| `ir` pattern | Instruction class | Target |
|---|---|---|
| `ir[27:25]`=000, `ir[4]`=0 | data processing, immediate shift | 4 |
| `ir[27:25]`=000, `ir[4]`=1 | data processing, register shift | 6 |
| `ir[27:25]`=001 | data processing, immediate | 8 |
| `ir[27:25]`=010, `ir[20]`=1 | load, immediate offset | 11 |
| `ir[27:25]`=010, `ir[20]`=0 | store, immediate offset | 45 |
| `ir[27:25]`=011, `ir[20]`=1 | load, register offset | 13 |
| `ir[27:25]`=011, `ir[20]`=0 | store, register offset | 47 |
| `ir[27:25]`=100 | block transfer | 81 |
| `ir[27:25]`=101 | branch | 40 |
| anything else | undefined instruction | 0 |

**Arithmetic**
- index+1 is computed modulo 128, so 127 wraps to 0.

**Wait watchdog**
- An 8-bit counter clears whenever ns≠4 or `moc`=1.
- The counter increments on each stalled cycle.
- When the counter reaches WAIT_LIMIT−1 and `moc` is still low:
  - next = FAULT_ADDR;
  - `fault` sets;
  - the counter clears.
- If `moc` rises on the limit cycle, `moc` wins: normal increment, no fault.
- `fault` clears only on reset.

## Timing
- **Reset:**
  - index = 0, `stall` = 0, `fault` = 0;
  - watchdog counter = 0, return register = 0.
  - Reset overrides everything, including mid-wait and a simultaneous `moc`.
- **Sequencing:**
  - One microinstruction per cycle.
  - `cw` is valid combinationally in the same cycle as `index`.
  - next is registered on the rising edge of `clk`.
  - Latency from an input change to a new index is one edge.
- **`stall`:** combinational, equal to (ns==4 && !`moc`). It is 0 during reset.
- **`moc`:**
  - Sampled only while ns==4.
  - `moc` asserted at other times is ignored; the sequencer does not latch it.
- **Inputs:** `ir` and `cond_true` are sampled at the edge that leaves the dispatch or branch microinstruction.

## Configuration
- `MICROSEQ_SUBR_EN` defined:
  - A one-entry return register is added.
  - ns=6 (call): return register ← index+1, next = cr.
  - ns=7 (return): next = return register.
  - A call executed while an entry is live overwrites it; there is no nesting.
- `MICROSEQ_SUBR_EN` undefined:
  - No return register is built.
  - ns=6 and ns=7 both behave as increment.

## Structure
- Shared package `microseq_pkg` holds:
  - the ns encodings `NS_INC`, `NS_JMP`, `NS_DISP`, `NS_CBR`, `NS_WAIT`, `NS_CDISP`, `NS_CALL`, `NS_RET`;
  - the csel encodings;
  - the field bit positions;
  - the dispatch address constants.
- Sub-module `instr_encoder` is purely combinational: `ir` → 7-bit start address.
- The top level contains the µPC register, the next-address mux, the watchdog and the return register.

## Test plan
1. **Reset and increment:** assert `reset` for 2 cycles, then release with cw ns=0. Index must read 0 after reset, then 1, then 2 on successive edges.
2. **Dispatch:** ns=2 with `ir`=32'hE0810002 (ADD, register operand). The next index must be 4. Repeat with `ir`=32'hEA000001 (branch): the next index must be 40.
3. **Conditional branch:** ns=3, csel=0, cr=92.
   - `cond_true`=1 → next index 92.
   - `cond_true`=0 → next index = index+1.
   - inv=1 with `cond_true`=1 → next index = index+1.
4. **Wait and timeout:**
   - ns=4 at index 9, `moc`=0 for 3 cycles, then 1. Index must hold at 9 with `stall`=1 for 3 cycles, then go to 10.
   - Repeat with `moc` held low. After 16 cycles, index must be 0 and `fault` must be 1 and stay set.
5. **Wrap and mid-wait reset:**
   - ns=0 at index 127 → next index 0.
   - Assert `reset` during a stall with `moc`=1 → index 0, `stall`=0, `fault`=0.
6. **Subroutine (with `MICROSEQ_SUBR_EN`):**
   - Call at index 20 with cr=90 → next index 90.
   - Return at 90 → next index 21.
   - Without the macro, both microinstructions behave as increment: index goes 20→21.
